// File: rtl/bitlet_ce_stream_pkg.sv
// Shared defaults for the bit-plane compute engine stream.
//   DEF_* : default job geometry used when the top is instantiated bare.
//   sel_width() : index width for an N-entry job (at least one bit).
package bitlet_ce_stream_pkg;

  localparam int DEF_N_TOTAL   = 64;
  localparam int DEF_N_CHANNEL = 8;
  localparam int DEF_WID_ABS   = 8;
  localparam int DEF_WID_FIX   = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitlet_ce_lane.sv
// One bit-plane lane: holds the pending-element mask for a single weight
// bit position and walks it lowest-index first.
//   clk_i        : clock
//   clr_i        : synchronous clear (reset or flush)
//   load_i       : load load_mask_i at the next edge (wins over fire_i)
//   load_mask_i  : new pending mask
//   fire_i       : output beat consumed; drop the current selection
//   lane_vld_o   : lane still has a pending element
//   sel_o        : lowest pending element index
//   last_ok_o    : at most one pending element remains
module bitlet_ce_lane
  import bitlet_ce_stream_pkg::*;
#(
  parameter int N_TOTAL = DEF_N_TOTAL,
  localparam int WID_SEL = sel_width(N_TOTAL)
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [N_TOTAL-1:0] load_mask_i,
  input  logic               fire_i,
  output logic               lane_vld_o,
  output logic [WID_SEL-1:0] sel_o,
  output logic               last_ok_o
);

  localparam logic [N_TOTAL-1:0] ONE = {{(N_TOTAL-1){1'b0}}, 1'b1};

  logic [N_TOTAL-1:0] pending_q, pending_d;
  logic [N_TOTAL-1:0] rest;

  // x & (x-1) strips the lowest set bit: it is both the post-fire mask and,
  // when zero, the proof that at most one element is left.
  assign rest       = pending_q & (pending_q - ONE);
  assign lane_vld_o = |pending_q;
  assign last_ok_o  = ~|rest;

  always_comb begin
    sel_o = '0;
    for (int k = N_TOTAL - 1; k >= 0; k--) begin
      if (pending_q[k]) sel_o = WID_SEL'(k);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (load_i)      pending_d = load_mask_i;
    else if (fire_i) pending_d = rest;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/bitlet_ce_stream.sv
// Bit-plane compute engine front end with ready/valid on both sides.
// A job (weight magnitudes + activations) is transposed into one pending
// mask per weight bit; each beat every lane presents the activation at its
// lowest remaining set weight bit until all lanes drain.
//   clk, rst, flush        : clock, sync active-high reset, sync job abort
//   lane_en, n_calc        : lane prune mask and last active element, sampled at load
//   in_vld/in_rdy          : job handshake; wabs_vec/afix_vec packed per element
//   out_vld/out_rdy        : beat handshake; outputs hold while stalled
//   out_lane_vld/idx/afix  : per-lane selection, zero on idle lanes
//   out_last               : final beat of the job
//   done                   : one-cycle completion pulse
module bitlet_ce_stream
  import bitlet_ce_stream_pkg::*;
#(
  parameter int N_TOTAL   = DEF_N_TOTAL,
  parameter int N_CHANNEL = DEF_N_CHANNEL,
  parameter int WID_ABS   = DEF_WID_ABS,
  parameter int WID_FIX   = DEF_WID_FIX,
  localparam int WID_SEL  = sel_width(N_TOTAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [N_CHANNEL-1:0]         lane_en,
  input  logic [WID_SEL-1:0]           n_calc,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [N_TOTAL*WID_ABS-1:0]   wabs_vec,
  input  logic [N_TOTAL*WID_FIX-1:0]   afix_vec,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [N_CHANNEL-1:0]         out_lane_vld,
  output logic [N_CHANNEL*WID_SEL-1:0] out_idx,
  output logic [N_CHANNEL*WID_FIX-1:0] out_afix,
  output logic                         out_last,
  output logic                         done
);

  logic                             clr;
  logic                             busy;
  logic                             fire;
  logic                             accept;
  logic                             load_empty;
  logic [N_CHANNEL-1:0]             lane_vld;
  logic [N_CHANNEL-1:0]             last_ok;
  logic [WID_SEL-1:0]               sel [N_CHANNEL];
  logic [N_CHANNEL-1:0][N_TOTAL-1:0] load_mask;

  logic [WID_FIX-1:0] afix_q [N_TOTAL];
  logic               done_q, done_d;
  logic               done_extra_q, done_extra_d;
  logic               ev_old, ev_new;

  // Weight bits above the lane count never reach a lane.
  logic unused_wabs;
  assign unused_wabs = ^wabs_vec;

  assign clr      = rst | flush;
  assign busy     = |lane_vld;
  assign out_vld  = busy;
  assign out_last = busy & (&last_ok);
  assign fire     = out_vld & out_rdy;
  // Accepting on the last fire lets the next job start with no bubble.
  assign in_rdy   = ~rst & ~flush & (~busy | (fire & out_last));
  assign accept   = in_vld & in_rdy;

  always_comb begin
    load_mask = '0;
    for (int c = 0; c < N_CHANNEL; c++) begin
      for (int k = 0; k < N_TOTAL; k++) begin
        load_mask[c][k] = wabs_vec[k*WID_ABS + c] & lane_en[c]
                          & (WID_SEL'(k) <= n_calc);
      end
    end
  end

  assign load_empty = ~|load_mask;

  for (genvar c = 0; c < N_CHANNEL; c++) begin : g_lane
    bitlet_ce_lane #(
      .N_TOTAL (N_TOTAL)
    ) u_lane (
      .clk_i       (clk),
      .clr_i       (clr),
      .load_i      (accept),
      .load_mask_i (load_mask[c]),
      .fire_i      (fire),
      .lane_vld_o  (lane_vld[c]),
      .sel_o       (sel[c]),
      .last_ok_o   (last_ok[c])
    );
  end

  assign out_lane_vld = lane_vld;

  always_comb begin
    out_idx  = '0;
    out_afix = '0;
    for (int c = 0; c < N_CHANNEL; c++) begin
      if (lane_vld[c]) begin
        out_idx[c*WID_SEL +: WID_SEL]  = sel[c];
        out_afix[c*WID_FIX +: WID_FIX] = afix_q[sel[c]];
      end
    end
  end

  // Two completions can land on one edge (last fire plus an empty load);
  // the second one is parked in done_extra_q and pulses a cycle later.
  // An empty job leaves the engine idle, so a parked pulse never meets
  // another last fire.
  always_comb begin
    ev_old       = done_extra_q | (fire & out_last);
    ev_new       = accept & load_empty;
    done_d       = ev_old | ev_new;
    done_extra_d = ev_old & ev_new;
  end

  assign done = done_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      done_q       <= 1'b0;
      done_extra_q <= 1'b0;
      afix_q       <= '{default: '0};
    end else begin
      done_q       <= done_d;
      done_extra_q <= done_extra_d;
      if (accept) begin
        for (int g = 0; g < N_TOTAL; g++) begin
          afix_q[g] <= afix_vec[g*WID_FIX +: WID_FIX];
        end
      end
    end
  end

endmodule

// File: tb/tb_bitlet_ce_stream.sv
module tb_bitlet_ce_stream;

  localparam int NT = 8;
  localparam int NC = 2;
  localparam int WA = 2;
  localparam int WF = 16;
  localparam int WS = 3;

  logic              clk = 1'b0;
  logic              rst, flush, in_vld, out_rdy;
  logic [NC-1:0]     lane_en;
  logic [WS-1:0]     n_calc;
  logic [NT*WA-1:0]  wabs_vec;
  logic [NT*WF-1:0]  afix_vec;
  logic              in_rdy, out_vld, out_last, done;
  logic [NC-1:0]     out_lane_vld;
  logic [NC*WS-1:0]  out_idx;
  logic [NC*WF-1:0]  out_afix;

  int total = 0;
  int bad   = 0;

  bitlet_ce_stream #(
    .N_TOTAL(NT), .N_CHANNEL(NC), .WID_ABS(WA), .WID_FIX(WF)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .lane_en(lane_en), .n_calc(n_calc),
    .in_vld(in_vld), .in_rdy(in_rdy), .wabs_vec(wabs_vec), .afix_vec(afix_vec),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_lane_vld(out_lane_vld),
    .out_idx(out_idx), .out_afix(out_afix), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: per lane, the ordered list of element indices whose
  // weight bit is set, restricted by lane_en and n_calc. Beat b carries the
  // b-th entry of every list that is long enough.
  int              m_nb;
  logic [NC-1:0]   m_lv  [NT];
  logic [NC*WS-1:0] m_idx [NT];
  logic [WF-1:0]   m_af  [NT];

  function automatic void build_model(input logic [NT*WA-1:0] w, input logic [NC-1:0] en,
                                      input logic [WS-1:0] nc, input logic [NT*WF-1:0] af);
    int cnt;
    m_nb = 0;
    for (int b = 0; b < NT; b++) begin
      m_lv[b]  = '0;
      m_idx[b] = '0;
      m_af[b]  = af[b*WF +: WF];
    end
    for (int c = 0; c < NC; c++) begin
      cnt = 0;
      for (int k = 0; k < NT; k++) begin
        if (en[c] && k <= int'(nc) && w[k*WA + c]) begin
          m_lv[cnt][c] = 1'b1;
          m_idx[cnt][c*WS +: WS] = WS'(k);
          cnt++;
        end
      end
      if (cnt > m_nb) m_nb = cnt;
    end
  endfunction

  task automatic check_beat(input int b);
    logic [NC*WF-1:0] exp_af;
    logic [WS-1:0]    ix;
    exp_af = '0;
    for (int c = 0; c < NC; c++) begin
      ix = m_idx[b][c*WS +: WS];
      if (m_lv[b][c]) exp_af[c*WF +: WF] = m_af[ix];
    end
    chk("beat_vld", out_vld, 1'b1);
    chk("beat_lane_vld", out_lane_vld, m_lv[b]);
    chk("beat_idx", out_idx, m_idx[b]);
    chk("beat_afix", out_afix, exp_af);
    chk("beat_last", out_last, b == m_nb - 1);
    chk("beat_in_rdy", in_rdy, out_rdy && (b == m_nb - 1));
  endtask

  task automatic drive_job(input logic [NT*WA-1:0] w, input logic [NC-1:0] en,
                           input logic [WS-1:0] nc, input logic [NT*WF-1:0] af, input bit hold);
    wabs_vec = w; lane_en = en; n_calc = nc; afix_vec = af; in_vld = 1'b1;
    #1 chk("in_rdy_load", in_rdy, 1'b1);
    @(negedge clk);
    if (!hold) in_vld = 1'b0;
  endtask

  task automatic drain(input int rdy_pct, input logic first_done);
    int b = 0;
    int cyc = 0;
    if (m_nb == 0) begin
      #1;
      chk("empty_vld", out_vld, 1'b0);
      chk("empty_done", done, 1'b1);
      chk("empty_in_rdy", in_rdy, 1'b1);
      @(negedge clk);
      #1 chk("empty_done_once", done, 1'b0);
      @(negedge clk);
      return;
    end
    while (b < m_nb && cyc < 100) begin
      out_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      check_beat(b);
      chk("done_mid", done, (cyc == 0) ? first_done : 1'b0);
      if (out_rdy) b++;
      cyc++;
      @(negedge clk);
    end
    chk("drain_beats", b, m_nb);
    #1;
    chk("done_end", done, 1'b1);
    chk("vld_end", out_vld, 1'b0);
    @(negedge clk);
    #1 chk("done_once", done, 1'b0);
    @(negedge clk);
  endtask

  typedef struct {
    logic             rdy;
    logic             vld;
    logic [NC-1:0]    lv;
    logic [NC*WS-1:0] idx;
    logic [NC*WF-1:0] af;
    logic             last;
    logic             dn;
  } row_t;

  row_t tab [15];

  function automatic row_t mk(input bit rdy, input bit vld, input logic [1:0] lv,
                              input int i1, input int i0, input int a1, input int a0,
                              input bit last, input bit dn);
    row_t r;
    r.rdy = rdy; r.vld = vld; r.lv = lv;
    r.idx = {WS'(i1), WS'(i0)};
    r.af  = {WF'(a1), WF'(a0)};
    r.last = last; r.dn = dn;
    return r;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      out_rdy = tab[i].rdy;
      #1;
      chk($sformatf("row%0d_vld", i), out_vld, tab[i].vld);
      chk($sformatf("row%0d_lane_vld", i), out_lane_vld, tab[i].lv);
      chk($sformatf("row%0d_idx", i), out_idx, tab[i].idx);
      chk($sformatf("row%0d_afix", i), out_afix, tab[i].af);
      chk($sformatf("row%0d_last", i), out_last, tab[i].last);
      chk($sformatf("row%0d_done", i), done, tab[i].dn);
      chk($sformatf("row%0d_in_rdy", i), in_rdy, !tab[i].vld || (tab[i].rdy && tab[i].last));
      @(negedge clk);
    end
  endtask

  task automatic abort_job(input logic [NT*WA-1:0] w, input logic [NT*WF-1:0] af, input bit use_rst);
    build_model(w, 2'b11, 3'd7, af);
    drive_job(w, 2'b11, 3'd7, af, 1'b0);
    out_rdy = 1'b1;
    #1 check_beat(0);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    in_vld = 1'b1;
    #1 chk("abort_in_rdy", in_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_vld = 1'b0;
    #1;
    chk("abort_vld", out_vld, 1'b0);
    chk("abort_lane_vld", out_lane_vld, '0);
    chk("abort_idx", out_idx, '0);
    chk("abort_afix", out_afix, '0);
    chk("abort_last", out_last, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_in_rdy_after", in_rdy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", out_vld, 1'b0);
    end
    @(negedge clk);
  endtask

  logic [NT*WA-1:0] w_a, w_b, w_r;
  logic [NT*WF-1:0] af_a, af_r;
  int               wa [NT];

  initial begin
    wa = '{1, 0, 0, 2, 1, 0, 3, 0};
    for (int k = 0; k < NT; k++) begin
      w_a[k*WA +: WA]  = WA'(wa[k]);
      af_a[k*WF +: WF] = WF'(k + 10);
    end
    w_b = 16'hB4E1;

    // job 1: out_rdy held high
    tab[0]  = mk(1, 1, 2'b11, 3, 0, 13, 10, 0, 0);
    tab[1]  = mk(1, 1, 2'b11, 6, 4, 16, 14, 0, 0);
    tab[2]  = mk(1, 1, 2'b01, 0, 6, 0, 16, 1, 0);
    tab[3]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tab[4]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // job 2: out_rdy 1,0,0,1,1 holds beat 2
    tab[5]  = mk(1, 1, 2'b11, 3, 0, 13, 10, 0, 0);
    tab[6]  = mk(0, 1, 2'b11, 6, 4, 16, 14, 0, 0);
    tab[7]  = mk(0, 1, 2'b11, 6, 4, 16, 14, 0, 0);
    tab[8]  = mk(1, 1, 2'b11, 6, 4, 16, 14, 0, 0);
    tab[9]  = mk(1, 1, 2'b01, 0, 6, 0, 16, 1, 0);
    tab[10] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tab[11] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // job 3: lane_en=01, n_calc=3
    tab[12] = mk(1, 1, 2'b01, 0, 0, 0, 10, 1, 0);
    tab[13] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tab[14] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    lane_en = '0; n_calc = '0; wabs_vec = '0; afix_vec = '0;
    @(negedge clk);
    wabs_vec = w_a; afix_vec = af_a; lane_en = 2'b11; n_calc = 3'd7; in_vld = 1'b1;
    #1 chk("reset_in_rdy", in_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    #1;
    chk("reset_vld", out_vld, 1'b0);
    chk("reset_lane_vld", out_lane_vld, '0);
    chk("reset_idx", out_idx, '0);
    chk("reset_afix", out_afix, '0);
    chk("reset_last", out_last, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_in_rdy_after", in_rdy, 1'b1);
    @(negedge clk);

    drive_job(w_a, 2'b11, 3'd7, af_a, 1'b0);
    run_rows(0, 4);
    drive_job(w_a, 2'b11, 3'd7, af_a, 1'b0);
    run_rows(5, 11);
    drive_job(w_a, 2'b01, 3'd3, af_a, 1'b0);
    run_rows(12, 14);

    // all-zero weights: accepted, no beat, done next cycle
    build_model('0, 2'b11, 3'd7, af_a);
    drive_job('0, 2'b11, 3'd7, af_a, 1'b0);
    drain(100, 1'b0);

    // queued jobs with in_vld held high: B loads on A's last fire edge
    build_model(w_a, 2'b11, 3'd7, af_a);
    out_rdy = 1'b1;
    drive_job(w_a, 2'b11, 3'd7, af_a, 1'b1);
    wabs_vec = w_b; lane_en = 2'b11; n_calc = 3'd7; afix_vec = ~af_a;
    for (int b = 0; b < 3; b++) begin
      #1 check_beat(b);
      @(negedge clk);
    end
    in_vld = 1'b0;
    build_model(w_b, 2'b11, 3'd7, ~af_a);
    drain(100, 1'b1);

    abort_job(w_a, af_a, 1'b0);
    build_model(w_b, 2'b11, 3'd7, af_a);
    drive_job(w_b, 2'b11, 3'd7, af_a, 1'b0);
    drain(100, 1'b0);

    abort_job(w_a, af_a, 1'b1);
    build_model(w_a, 2'b10, 3'd7, af_a);
    drive_job(w_a, 2'b10, 3'd7, af_a, 1'b0);
    drain(70, 1'b0);

    for (int j = 0; j < 40; j++) begin
      logic [NC-1:0] en_r;
      logic [WS-1:0] nc_r;
      w_r  = WA*NT'($urandom);
      if ($urandom_range(7) == 0) w_r = '0;
      en_r = NC'($urandom_range(3));
      nc_r = WS'($urandom_range(NT - 1));
      for (int g = 0; g < NT; g++) af_r[g*WF +: WF] = WF'($urandom);
      build_model(w_r, en_r, nc_r, af_r);
      drive_job(w_r, en_r, nc_r, af_r, 1'b0);
      drain(60, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
